ahb_arbiter: RTL

AHB_ARBITER -- requirements
Module: ahb_arbiter

---
 rtl/ahb_arb_pkg.sv | 17 +
 rtl/rr_pick.sv | 25 ++
 rtl/ahb_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/ahb_arb_pkg.sv
// Shared encodings for the AHB bus arbiter: HTRANS values and arbiter FSM states.
package ahb_arb_pkg;

  localparam int unsigned HTRANS_W = 2;

  localparam logic [HTRANS_W-1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [HTRANS_W-1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [HTRANS_W-1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [HTRANS_W-1:0] HTRANS_SEQ    = 2'd3;

  typedef enum logic [1:0] {
    ST_PARK = 2'd0,
    ST_OWN  = 2'd1,
    ST_LOCK = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request after index last_i, wrapping.
module rr_pick #(
  parameter int unsigned NMST = 2
) (
  input  logic [NMST-1:0]         req_i,
  input  logic [$clog2(NMST)-1:0] last_i,
  output logic [NMST-1:0]         gnt_c_o,
  output logic                    valid_c_o
);

  // Offset k walks last+1 .. last+NMST; the first hit wins, so last itself has lowest priority.
  always_comb begin
    gnt_c_o   = '0;
    valid_c_o = 1'b0;
    for (int unsigned k = 1; k <= NMST; k++) begin
      for (int unsigned i = 0; i < NMST; i++) begin
        if (!valid_c_o && req_i[i] && (((32'(last_i) + k) % NMST) == i)) begin
          gnt_c_o[i] = 1'b1;
          valid_c_o  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: round-robin grant at arbitration points, parking on DEF_MST, locked-transfer hold.
module ahb_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int unsigned NMST    = 2,
  parameter int unsigned DEF_MST = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NMST-1:0]         hbusreq,
  input  logic [NMST-1:0]         hlock,
  input  logic [1:0]              htrans,
  input  logic                    hready,
  output logic [NMST-1:0]         hgrant,
  output logic [$clog2(NMST)-1:0] hmaster,
  output logic                    hmastlock
);

  localparam int unsigned IDXW = $clog2(NMST);
  localparam logic [NMST-1:0] DEF_GNT = {{(NMST-1){1'b0}}, 1'b1} << DEF_MST;
  localparam logic [IDXW-1:0] DEF_IDX = IDXW'(DEF_MST);

  arb_state_e      state_q, state_d;
  logic [NMST-1:0] hgrant_q, hgrant_d;
  logic [IDXW-1:0] hmaster_q, hmaster_d;
  logic            hmastlock_q, hmastlock_d;

  logic [IDXW-1:0] gnt_idx;
  logic [NMST-1:0] pick_gnt;
  logic            pick_valid;
  logic            arb_ok;
  logic            owner_lock;
  logic            do_arb;

  // The round-robin pointer is the index of the current grant, so it needs no separate register.
  always_comb begin
    gnt_idx = '0;
    for (int unsigned i = 0; i < NMST; i++) begin
      if (hgrant_q[i]) gnt_idx = IDXW'(i);
    end
  end

  assign arb_ok     = hready && ((htrans == HTRANS_IDLE) || (htrans == HTRANS_NONSEQ));
  assign owner_lock = |(hlock & hgrant_q);

  rr_pick #(
    .NMST (NMST)
  ) u_rr_pick (
    .req_i     (hbusreq),
    .last_i    (gnt_idx),
    .gnt_c_o   (pick_gnt),
    .valid_c_o (pick_valid)
  );

  // Next state: LOCK holds the grant until an arbitration point sees the owner's hlock low.
  always_comb begin
    state_d     = state_q;
    hgrant_d    = hgrant_q;
    hmaster_d   = hmaster_q;
    hmastlock_d = hmastlock_q;
    do_arb      = 1'b0;

    case (state_q)
      ST_PARK: do_arb = arb_ok;
      ST_OWN: begin
        if (arb_ok) begin
          if (owner_lock) state_d = ST_LOCK;
          else            do_arb  = 1'b1;
        end
      end
      ST_LOCK: do_arb = arb_ok && !owner_lock;
      default: state_d = ST_PARK;
    endcase

    if (do_arb) begin
      if (pick_valid) begin
        hgrant_d = pick_gnt;
        state_d  = ST_OWN;
      end else begin
        hgrant_d = DEF_GNT;
        state_d  = ST_PARK;
      end
    end

    // Address-phase owner follows the grant one hready-qualified edge later.
    if (hready) begin
      hmaster_d   = gnt_idx;
      hmastlock_d = owner_lock;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_PARK;
      hgrant_q    <= DEF_GNT;
      hmaster_q   <= DEF_IDX;
      hmastlock_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hgrant_q    <= hgrant_d;
      hmaster_q   <= hmaster_d;
      hmastlock_q <= hmastlock_d;
    end
  end

  assign hgrant    = hgrant_q;
  assign hmaster   = hmaster_q;
  assign hmastlock = hmastlock_q;

endmodule
